// File: rtl/automaton_frame_writer.sv
// Producer for the monochrome frame buffer: fills every row of the frame with an
// elementary cellular automaton, one 20-pixel word per cycle on RAM port A.
module automaton_frame_writer #(
    parameter int WORD_W        = 20,
    parameter int WORDS_PER_ROW = 64,
    parameter int ROWS          = 1024,
    parameter bit WRAP          = 1'b1
) (
    input  logic              clk108,
    input  logic              reset,
    input  logic              start,
    input  logic              pause,
    input  logic [7:0]        rule,
    input  logic [10:0]       seed_col,
    output logic [15:0]       address_a,
    output logic [WORD_W-1:0] data_a,
    output logic              wren_a,
    output logic              busy,
    output logic              done
);

    localparam int WB = $clog2(WORDS_PER_ROW);
    localparam int RB = $clog2(ROWS);
    localparam logic [WB-1:0] LAST_WORD = WB'(WORDS_PER_ROW - 1);
    localparam logic [RB-1:0] LAST_ROW  = RB'(ROWS - 1);

    typedef enum logic [1:0] {IDLE, SEED, GEN, DONE} state_t;

    state_t            state_r;
    logic [7:0]        rule_r;
    logic [10:0]       seed_r;
    logic [RB-1:0]     row_r;
    logic [WB-1:0]     word_r;
    logic              carry_r;
    logic              first_bit_r;
    logic [WORD_W-1:0] buf_r [WORDS_PER_ROW];

    logic [WORD_W-1:0] cur_old_s;
    logic [WORD_W-1:0] seed_word_s;
    logic [WORD_W-1:0] gen_word_s;
    logic              left_s;
    logic              right_s;

    // Row 0 word: only the pixel whose absolute column equals the seed is live.
    function automatic logic [WORD_W-1:0] seed_word(input logic [WB-1:0] w, input logic [10:0] col);
        logic [WORD_W-1:0] word;
        word = '0;
        for (int b = 0; b < WORD_W; b++) begin
            word[b] = ((int'(w) * WORD_W + b) == int'(col));
        end
        return word;
    endfunction

    // Next-generation word; ext holds {right neighbour, old word, left neighbour}.
    function automatic logic [WORD_W-1:0] next_word(input logic [7:0] rl, input logic [WORD_W-1:0] old,
                                                    input logic l, input logic r);
        logic [WORD_W+1:0] ext;
        logic [WORD_W-1:0] word;
        logic [2:0]        idx;
        ext  = {r, old, l};
        word = '0;
        for (int b = 0; b < WORD_W; b++) begin
            idx     = {ext[b], ext[b+1], ext[b+2]};
            word[b] = rl[idx];
        end
        return word;
    endfunction

    // Neighbour selection for the word currently being regenerated.
    always_comb begin
        cur_old_s = buf_r[word_r];
        left_s    = 1'b0;
        right_s   = 1'b0;
        if (word_r == '0) begin
            if (WRAP) begin
                left_s = buf_r[LAST_WORD][WORD_W-1];
            end else begin
                left_s = 1'b0;
            end
        end else begin
            left_s = carry_r;
        end
        if (word_r == LAST_WORD) begin
            if (WRAP) begin
                right_s = first_bit_r;
            end else begin
                right_s = 1'b0;
            end
        end else begin
            right_s = buf_r[word_r + WB'(1)][0];
        end
        seed_word_s = seed_word(word_r, seed_r);
        gen_word_s  = next_word(rule_r, cur_old_s, left_s, right_s);
    end

    // Frame sequencer: issues one registered RAM write per unpaused cycle.
    always_ff @(posedge clk108) begin
        if (reset) begin
            state_r     <= IDLE;
            rule_r      <= 8'd0;
            seed_r      <= 11'd0;
            row_r       <= '0;
            word_r      <= '0;
            carry_r     <= 1'b0;
            first_bit_r <= 1'b0;
            address_a   <= 16'd0;
            data_a      <= '0;
            wren_a      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done   <= 1'b0;
                    wren_a <= 1'b0;
                    if (start) begin
                        rule_r  <= rule;
                        seed_r  <= seed_col;
                        busy    <= 1'b1;
                        row_r   <= '0;
                        state_r <= SEED;
                        for (int i = 0; i < WORDS_PER_ROW; i++) begin
                            buf_r[i] <= '0;
                        end
                        // Word 0 goes out on the accept edge so the first write lands in the next cycle.
                        if (!pause) begin
                            address_a <= 16'd0;
                            data_a    <= seed_word('0, seed_col);
                            buf_r[0]  <= seed_word('0, seed_col);
                            wren_a    <= 1'b1;
                            word_r    <= WB'(1);
                        end else begin
                            word_r <= '0;
                        end
                    end
                end
                SEED: begin
                    if (pause) begin
                        wren_a <= 1'b0;
                    end else begin
                        address_a     <= 16'({row_r, word_r});
                        data_a        <= seed_word_s;
                        buf_r[word_r] <= seed_word_s;
                        wren_a        <= 1'b1;
                        if (word_r == LAST_WORD) begin
                            word_r  <= '0;
                            row_r   <= RB'(1);
                            state_r <= GEN;
                        end else begin
                            word_r <= word_r + WB'(1);
                        end
                    end
                end
                GEN: begin
                    if (pause) begin
                        wren_a <= 1'b0;
                    end else begin
                        address_a     <= 16'({row_r, word_r});
                        data_a        <= gen_word_s;
                        buf_r[word_r] <= gen_word_s;
                        wren_a        <= 1'b1;
                        carry_r       <= cur_old_s[WORD_W-1];
                        if (word_r == '0) begin
                            first_bit_r <= cur_old_s[0];
                        end
                        if (word_r == LAST_WORD) begin
                            word_r <= '0;
                            if (row_r == LAST_ROW) begin
                                state_r <= DONE;
                            end else begin
                                row_r <= row_r + RB'(1);
                            end
                        end else begin
                            word_r <= word_r + WB'(1);
                        end
                    end
                end
                DONE: begin
                    wren_a <= 1'b0;
                    if (!pause) begin
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        address_a <= 16'd0;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    wren_a  <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_automaton_frame_writer.sv
// Bench for automaton_frame_writer: a wrapping and a non-wrapping instance on a
// shortened frame, compared against a cell-level automaton model.
module tb_automaton_frame_writer;

    localparam int WPR   = 64;
    localparam int NROWS = 32;
    localparam int WW    = 20;
    localparam int FRAME = WPR * NROWS;
    localparam int NCOL  = WW * WPR;

    logic        clk108 = 1'b0;
    logic        reset;
    logic        start;
    logic        pause;
    logic [7:0]  rule;
    logic [10:0] seed_col;
    logic [15:0] address_a [2];
    logic [19:0] data_a    [2];
    logic        wren_a    [2];
    logic        busy      [2];
    logic        done      [2];

    automaton_frame_writer #(.WORD_W(20), .WORDS_PER_ROW(64), .ROWS(NROWS), .WRAP(1'b1)) u_dut_wrap (
        .clk108(clk108), .reset(reset), .start(start), .pause(pause), .rule(rule), .seed_col(seed_col),
        .address_a(address_a[0]), .data_a(data_a[0]), .wren_a(wren_a[0]), .busy(busy[0]), .done(done[0]));

    automaton_frame_writer #(.WORD_W(20), .WORDS_PER_ROW(64), .ROWS(NROWS), .WRAP(1'b0)) u_dut_flat (
        .clk108(clk108), .reset(reset), .start(start), .pause(pause), .rule(rule), .seed_col(seed_col),
        .address_a(address_a[1]), .data_a(data_a[1]), .wren_a(wren_a[1]), .busy(busy[1]), .done(done[1]));

    always #5 clk108 = ~clk108;

    int cyc = 0;
    always @(posedge clk108) cyc <= cyc + 1;

    logic [19:0] cap_mem [2][FRAME];
    logic [19:0] exp_mem [2][FRAME];
    int          writes_tot [2] = '{0, 0};
    int          done_tot   [2] = '{0, 0};
    int          done_cyc   [2] = '{0, 0};
    int          busy_bad   [2] = '{0, 0};
    int          seq_err    [2] = '{0, 0};
    logic [15:0] prev_addr  [2] = '{16'd0, 16'd0};

    int snap_w [2];
    int snap_d [2];
    int snap_b [2];
    int snap_s [2];
    int start_cyc;
    int extra_delay;
    int n_checks = 0;
    int n_fail   = 0;

    // Write monitor: captures RAM writes and tracks sequencing, busy and done.
    always @(negedge clk108) begin
        for (int k = 0; k < 2; k++) begin
            if (wren_a[k]) begin
                if (address_a[k] < 16'(FRAME)) cap_mem[k][address_a[k][10:0]] <= data_a[k];
                if (address_a[k] != 16'd0 && address_a[k] != prev_addr[k] + 16'd1) seq_err[k] <= seq_err[k] + 1;
                if (!busy[k]) busy_bad[k] <= busy_bad[k] + 1;
                prev_addr[k]  <= address_a[k];
                writes_tot[k] <= writes_tot[k] + 1;
            end
            if (done[k]) begin
                done_tot[k] <= done_tot[k] + 1;
                done_cyc[k] <= cyc;
                if (busy[k]) busy_bad[k] <= busy_bad[k] + 1;
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: evolve a 1280-cell row with the Wolfram rule, then pack 20 cells per word.
    task automatic build_expected(input logic [7:0] r, input logic [10:0] s);
        bit          cur [NCOL];
        bit          nxt [NCOL];
        bit          l, rr, wrap;
        logic [2:0]  idx;
        logic [19:0] word_v;
        for (int inst = 0; inst < 2; inst++) begin
            wrap = (inst == 0);
            for (int c = 0; c < NCOL; c++) cur[c] = (c == int'(s));
            for (int row = 0; row < NROWS; row++) begin
                for (int w = 0; w < WPR; w++) begin
                    for (int b = 0; b < WW; b++) word_v[b] = cur[w * WW + b];
                    exp_mem[inst][row * WPR + w] = word_v;
                end
                for (int c = 0; c < NCOL; c++) begin
                    if (c == 0) l = wrap ? cur[NCOL-1] : 1'b0;
                    else l = cur[c-1];
                    if (c == NCOL - 1) rr = wrap ? cur[0] : 1'b0;
                    else rr = cur[c+1];
                    idx    = {l, cur[c], rr};
                    nxt[c] = r[idx];
                end
                cur = nxt;
            end
        end
    endtask

    task automatic take_snapshot();
        for (int k = 0; k < 2; k++) begin
            snap_w[k] = writes_tot[k];
            snap_d[k] = done_tot[k];
            snap_b[k] = busy_bad[k];
            snap_s[k] = seq_err[k];
        end
    endtask

    task automatic begin_frame(input logic [7:0] r, input logic [10:0] s, input int pause_edges);
        build_expected(r, s);
        @(negedge clk108);
        #1;
        take_snapshot();
        rule        = r;
        seed_col    = s;
        start       = 1'b1;
        pause       = (pause_edges > 0);
        extra_delay = pause_edges;
        @(posedge clk108);
        #1;
        start_cyc = cyc - 1;
        start     = 1'b0;
        if (pause_edges > 0) begin
            repeat (pause_edges - 1) @(posedge clk108);
            #1;
            pause = 1'b0;
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < FRAME + 200; i++) begin
            @(negedge clk108);
            #1;
            if (done_tot[0] > snap_d[0] && done_tot[1] > snap_d[1]) break;
        end
        repeat (4) @(negedge clk108);
        #1;
    endtask

    task automatic end_frame(input string name);
        int mm;
        for (int k = 0; k < 2; k++) begin
            mm = 0;
            for (int i = 0; i < FRAME; i++) if (cap_mem[k][i] !== exp_mem[k][i]) mm++;
            check_val($sformatf("%s/%0d writes", name, k), 32'(writes_tot[k] - snap_w[k]), 32'(FRAME));
            check_val($sformatf("%s/%0d done_count", name, k), 32'(done_tot[k] - snap_d[k]), 32'd1);
            check_val($sformatf("%s/%0d done_latency", name, k), 32'(done_cyc[k] - start_cyc), 32'(FRAME + 1 + extra_delay));
            check_val($sformatf("%s/%0d busy_errors", name, k), 32'(busy_bad[k] - snap_b[k]), 32'd0);
            check_val($sformatf("%s/%0d addr_sequence", name, k), 32'(seq_err[k] - snap_s[k]), 32'd0);
            check_val($sformatf("%s/%0d data_mismatches", name, k), 32'(mm), 32'd0);
        end
    endtask

    task automatic wait_addr(input logic [15:0] a, output bit found);
        found = 1'b0;
        for (int i = 0; i < FRAME + 50; i++) begin
            @(negedge clk108);
            if (wren_a[0] && address_a[0] == a) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit          found;
        int          bad;
        int          w_snap;
        logic [19:0] held;

        reset = 1'b1; start = 1'b0; pause = 1'b0; rule = 8'd0; seed_col = 11'd0;
        repeat (3) @(posedge clk108);
        @(negedge clk108);
        for (int k = 0; k < 2; k++) begin
            check_val($sformatf("reset/%0d address", k), 32'(address_a[k]), 32'd0);
            check_val($sformatf("reset/%0d outputs", k), 32'({data_a[k], wren_a[k], busy[k], done[k]}), 32'd0);
        end
        reset = 1'b0;

        // rule 0 with a start pulse and input changes mid-frame, all of which must be ignored
        begin_frame(8'd0, 11'd640, 0);
        repeat (500) @(negedge clk108);
        start = 1'b1; rule = 8'hFF; seed_col = 11'd3;
        @(negedge clk108);
        start = 1'b0; rule = 8'd90;
        wait_done();
        end_frame("rule0");
        bad = 0;
        for (int i = WPR; i < FRAME; i++) if (cap_mem[0][i] != 20'd0) bad++;
        check_val("rule0 word32", 32'(cap_mem[0][32]), 32'h00001);
        check_val("rule0 rows_nonzero", 32'(bad), 32'd0);

        begin_frame(8'd204, 11'd5, 0);
        wait_done();
        end_frame("rule204");
        bad = 0;
        for (int i = 0; i < FRAME; i++) if (cap_mem[0][i] != ((i % WPR == 0) ? 20'h00020 : 20'h00000)) bad++;
        check_val("rule204 identity_words", 32'(bad), 32'd0);

        begin_frame(8'd90, 11'd640, 0);
        wait_done();
        end_frame("rule90c640");
        check_val("rule90 r1w31", 32'(cap_mem[0][WPR + 31]), 32'h80000);
        check_val("rule90 r1w32", 32'(cap_mem[0][WPR + 32]), 32'h00002);
        check_val("rule90 r2w31", 32'(cap_mem[0][2 * WPR + 31]), 32'h40000);
        check_val("rule90 r2w32", 32'(cap_mem[0][2 * WPR + 32]), 32'h00004);

        begin_frame(8'd90, 11'd0, 0);
        wait_done();
        end_frame("rule90c0");
        check_val("wrap r1w0", 32'(cap_mem[0][WPR]), 32'h00002);
        check_val("wrap r1w63", 32'(cap_mem[0][WPR + 63]), 32'h80000);
        check_val("flat r1w0", 32'(cap_mem[1][WPR]), 32'h00002);
        check_val("flat r1w63", 32'(cap_mem[1][WPR + 63]), 32'h00000);

        // ten-cycle pause with address 1000 on the bus
        begin_frame(8'd30, 11'd640, 0);
        wait_addr(16'd1000, found);
        check_val("pause reach1000", 32'(found), 32'd1);
        held  = data_a[0];
        pause = 1'b1;
        bad   = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk108);
            @(negedge clk108);
            if (wren_a[0] || wren_a[1] || address_a[0] != 16'd1000 || address_a[1] != 16'd1000 || data_a[0] != held) bad++;
        end
        pause = 1'b0;
        extra_delay = 10;
        check_val("pause hold", 32'(bad), 32'd0);
        wait_done();
        end_frame("pause");

        // start and pause together: first write waits three edges
        begin_frame(8'd110, 11'd1279, 3);
        wait_done();
        end_frame("start_pause");

        // reset mid-frame at address 300
        begin_frame(8'd150, 11'd700, 0);
        wait_addr(16'd300, found);
        check_val("reset reach300", 32'(found), 32'd1);
        reset = 1'b1;
        @(posedge clk108);
        #1;
        reset = 1'b0;
        @(negedge clk108);
        for (int k = 0; k < 2; k++) begin
            check_val($sformatf("midreset/%0d address", k), 32'(address_a[k]), 32'd0);
            check_val($sformatf("midreset/%0d wren_busy_done", k), 32'({wren_a[k], busy[k], done[k]}), 32'd0);
        end
        #1;
        w_snap = writes_tot[0] + writes_tot[1];
        repeat (30) @(negedge clk108);
        #1;
        check_val("midreset no_writes", 32'(writes_tot[0] + writes_tot[1] - w_snap), 32'd0);
        check_val("midreset idle_busy", 32'({busy[0], busy[1]}), 32'd0);

        for (int f = 0; f < 3; f++) begin
            begin_frame(8'($urandom_range(0, 255)), 11'($urandom_range(0, 1400)), 0);
            wait_done();
            end_frame($sformatf("random%0d", f));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
